// File: rtl/isqrt_shared_arbiter.sv
// Shares one pipelined isqrt unit among N_REQ requesters (round-robin), routing results back via an in-order tag FIFO.
// Define ISQRT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module isqrt_shared_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic [N_REQ*W-1:0] req_x,
  output logic [N_REQ-1:0]   res_vld,
  output logic [W-1:0]       res_y,
  output logic               x_vld,
  output logic [W-1:0]       x,
  input  logic               y_vld,
  input  logic [W-1:0]       y,
  output logic               err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
`ifndef ISQRT_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr;
`endif

  logic             pop, push, can_issue;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A result popping this cycle frees a slot, so a full FIFO can still accept.
  assign pop       = y_vld && (count != '0);
  assign can_issue = (count < CNT_W'(DEPTH)) || pop;

  always_comb begin : arb_comb
    int   idx;
    logic found;
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    found     = 1'b0;
    if (can_issue) begin
      for (int k = 0; k < N_REQ; k++) begin
`ifdef ISQRT_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(rr) + k) % N_REQ;
`endif
        if (!found && req_vld[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
        end
      end
    end
  end

  assign req_rdy = rst ? '0 : grant;
  assign push    = |(req_vld & req_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      x_vld   <= 1'b0;
      x       <= '0;
      res_vld <= '0;
      res_y   <= '0;
`ifndef ISQRT_ARB_FIXED_PRIO_EN
      rr      <= '0;
`endif
    end else begin
      // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
      x_vld <= push;
      if (push) begin
        x      <= req_x[int'(grant_idx)*W +: W];
        wr_ptr <= ptr_inc(wr_ptr);
`ifndef ISQRT_ARB_FIXED_PRIO_EN
        rr     <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
`endif
      end
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        res_vld <= N_REQ'(1) << tag_mem[rd_ptr];
        res_y   <= y;
      end else begin
        res_vld <= '0;
      end
      // A result with nothing in flight has no owner: drop it and flag.
      if (y_vld && (count == '0)) err <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: tag storage is not reset; count and the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) tag_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Self-checking bench for isqrt_shared_arbiter: queue-based reference model plus directed scenarios.
// A stub isqrt unit (fixed latency, optional hold-back) sits behind the arbiter.
module tb_isqrt_shared_arbiter;
  localparam int N = 4, W = 32, DEPTH = 16, LAT = 3;
`ifdef ISQRT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_vld = '0, req_rdy, res_vld;
  logic [N*W-1:0] req_x = '0;
  logic [W-1:0]   res_y, x, y = '0;
  logic           x_vld, err, y_vld = 1'b0;

  isqrt_shared_arbiter #(.N_REQ(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x),
    .res_vld(res_vld), .res_y(res_y), .x_vld(x_vld), .x(x),
    .y_vld(y_vld), .y(y), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int owner; logic [W-1:0] arg; } txn_t;
  typedef struct { logic [W-1:0] arg; int t; } unit_t;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] isqrt_ref(input logic [W-1:0] v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return W'(r);
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Requester argument queues, stub unit and injection controls.
  logic [W-1:0] pend [N][$];
  unit_t        sq[$];
  bit           hold = 1'b0, inj_vld = 1'b0, unit_vld = 1'b0, rst_req = 1'b1;
  logic [W-1:0] inj_y = '0, unit_y = '0;
  logic [N-1:0] granted_s = '0;
  int           cyc = 0;

  // Reference model state: expected registered outputs for the coming cycle.
  txn_t         m_q[$];
  int           m_rr = 0, m_g = -1, m_idx = 0;
  bit           m_valid = 1'b0, m_err = 1'b0, m_pop = 1'b0;
  bit           e_xv = 1'b0;
  logic [W-1:0] e_x = '0, e_ry = '0;
  logic [N-1:0] e_rv = '0, m_eg = '0;
  txn_t         m_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_req;
    for (int i = 0; i < N; i++) if (granted_s[i]) void'(pend[i].pop_front());
    if (x_vld) sq.push_back('{arg: x, t: cyc});
    if (!hold && sq.size() > 0 && sq[0].t + LAT <= cyc) begin
      unit_vld = 1'b1;
      unit_y   = isqrt_ref(sq[0].arg);
      void'(sq.pop_front());
    end else begin
      unit_vld = 1'b0;
    end
    y_vld = unit_vld | inj_vld;
    y     = inj_vld ? inj_y : unit_y;
    for (int i = 0; i < N; i++) begin
      req_vld[i]       = pend[i].size() > 0;
      req_x[i*W +: W]  = (pend[i].size() > 0) ? pend[i][0] : '0;
    end
    #1;
  endtask

  function automatic bit idle();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b0;
    return (sq.size() == 0) && (m_q.size() == 0);
  endfunction

  task automatic drain();
    int k = 0;
    while (k < 300 && !idle()) begin tick(); k++; end
    tick(); tick();
    check("drain_done", 64'(k < 300), 1);
  endtask

  task automatic reset_pulse(input int n);
    rst_req = 1'b1;
    repeat (n) tick();
    rst_req = 1'b0;
    tick();
  endtask

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    granted_s = req_rdy & req_vld;
    if (m_valid) begin
      check("x_vld", 64'(x_vld), 64'(e_xv));
      check("x", 64'(x), 64'(e_x));
      check("res_vld", 64'(res_vld), 64'(e_rv));
      check("res_y", 64'(res_y), 64'(e_ry));
      check("err", 64'(err), 64'(m_err));
    end
    if (rst) begin
      check("rdy_in_rst", 64'(req_rdy), 0);
      m_q.delete();
      m_rr = 0; m_err = 1'b0; e_xv = 1'b0; e_x = '0; e_rv = '0; e_ry = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_pop = y_vld && m_q.size() > 0;
      m_eg  = '0;
      m_g   = -1;
      if (m_q.size() < DEPTH || m_pop) begin
        for (int k = 0; k < N; k++) begin
          m_idx = FIXED ? k : (m_rr + k) % N;
          if (m_g < 0 && req_vld[m_idx]) m_g = m_idx;
        end
      end
      if (m_g >= 0) m_eg[m_g] = 1'b1;
      check("req_rdy", 64'(req_rdy), 64'(m_eg));
      if (y_vld && m_q.size() == 0) m_err = 1'b1;
      if (m_pop) begin
        m_t  = m_q.pop_front();
        e_rv = N'(1) << m_t.owner;
        e_ry = isqrt_ref(m_t.arg);
      end else begin
        e_rv = '0;
      end
      if (m_g >= 0) begin
        e_xv = 1'b1;
        e_x  = req_x[m_g*W +: W];
        m_q.push_back('{owner: m_g, arg: req_x[m_g*W +: W]});
        m_rr = (m_g + 1) % N;
      end else begin
        e_xv = 1'b0;
      end
    end
  end

  initial begin
    int lat, ngr, first_g, last_g;
    int gseq[$], rseq_o[$];
    logic [W-1:0] rseq_y[$];

    reset_pulse(3);
    check("rst_x_vld", 64'(x_vld), 0);
    check("rst_res_vld", 64'(res_vld), 0);
    check("rst_err", 64'(err), 0);

    // Single request from requester 1.
    pend[1].push_back(144);
    tick();
    check("t1_grant", 64'(req_rdy), 4'b0010);
    lat = 0;
    while (lat < 20 && res_vld == '0) begin tick(); lat++; end
    check("t1_latency", lat, LAT + 2);
    check("t1_res_vld", 64'(res_vld), 4'b0010);
    check("t1_res_y", 64'(res_y), 12);
    check("t1_err", 64'(err), 0);
    drain();

    // All four requesting continuously.
    reset_pulse(2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) pend[i].push_back(W'((i + 2) * (i + 2)));
    first_g = -1; last_g = -1;
    for (int k = 0; k < 40 && rseq_o.size() < 8; k++) begin
      tick();
      if (req_rdy != '0 && gseq.size() < 8) begin
        gseq.push_back(oh2i(req_rdy));
        if (first_g < 0) first_g = k;
        last_g = k;
      end
      if (res_vld != '0) begin
        rseq_o.push_back(oh2i(res_vld));
        rseq_y.push_back(res_y);
      end
    end
    check("t2_n_results", rseq_o.size(), 8);
    check("t2_back_to_back", last_g - first_g, 7);
`ifndef ISQRT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < rseq_o.size() && k < gseq.size(); k++) begin
      check("t2_grant_order", gseq[k], k % 4);
      check("t2_res_owner", rseq_o[k], k % 4);
      check("t2_res_y", 64'(rseq_y[k]), (k % 4) + 2);
    end
`endif
    drain();

    // Fill the tag FIFO while the unit holds results back.
    hold = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++) pend[i].push_back(W'(1000 * i + 7 * k + 50));
    ngr = 0;
    repeat (20) begin
      tick();
      if (req_rdy != '0) ngr++;
    end
    check("t3_grants", ngr, DEPTH);
    check("t3_full_rdy", 64'(req_rdy), 0);
    hold = 1'b0;
    tick();
    check("t3_pop_y_vld", 64'(y_vld), 1);
    check("t3_pop_regrant", 64'(req_rdy), FIXED ? 4'b1000 : 4'b0001);
    drain();

    // Underflow: result with nothing in flight.
    inj_y = 7; inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    tick();
    check("t4_err_rise", 64'(err), 1);
    check("t4_no_res", 64'(res_vld), 0);
    repeat (3) tick();
    check("t4_err_sticky", 64'(err), 1);
    reset_pulse(2);
    check("t4_err_clear", 64'(err), 0);

    // Reset with five arguments outstanding.
    hold = 1'b1;
    pend[0].push_back(1); pend[0].push_back(25);
    pend[1].push_back(4); pend[2].push_back(9); pend[3].push_back(16);
    for (int k = 0; k < 20 && !(pend[0].size() == 0 && pend[1].size() == 0 &&
                                pend[2].size() == 0 && pend[3].size() == 0); k++) tick();
    check("t5_outstanding", sq.size(), 5);
    rst_req = 1'b1;
    repeat (3) tick();
    check("t5_rst_x_vld", 64'(x_vld), 0);
    check("t5_rst_x", 64'(x), 0);
    check("t5_rst_res_vld", 64'(res_vld), 0);
    check("t5_rst_res_y", 64'(res_y), 0);
    check("t5_rst_err", 64'(err), 0);
    check("t5_rst_rdy", 64'(req_rdy), 0);
    rst_req = 1'b0;
    hold = 1'b0;
    drain();
    check("t5_late_err", 64'(err), 1);
    pend[2].push_back(49);
    lat = 0;
    while (lat < 20 && res_vld == '0) begin tick(); lat++; end
    check("t5_fresh_res_vld", 64'(res_vld), 4'b0100);
    check("t5_fresh_res_y", 64'(res_y), 7);
    drain();

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 always wins.
    reset_pulse(2);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++) pend[i].push_back(W'(100 + 10 * i + k));
    repeat (4) begin
      tick();
      check("t6_fixed_grant", 64'(req_rdy), 4'b0001);
    end
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
